// File: rtl/food_pkg.sv
// rtl/food_pkg.sv - shared state encoding, coin values and item prices for the food machine
package food_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    localparam int MOEDA5  = 5;
    localparam int MOEDA10 = 10;
    localparam int MOEDA25 = 25;

    localparam int PRECO_PIZZA   = 45;
    localparam int PRECO_BURGUER = 40;
    localparam int PRECO_TORTA   = 30;
    localparam int PRECO_SODA    = 25;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer followed by a rising-edge pulse
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability, s3 remembers the previous synchronized level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/saldo_wallet.sv
// rtl/saldo_wallet.sv - credit keeper: coin intake, purchase debit, vend timing, change payout
module saldo_wallet
    import food_pkg::*;
#(
    parameter int W           = 6,
    parameter int SALDO_MAX   = 63,
    parameter int VEND_CYCLES = 8,
    parameter int CHANGE_UNIT = 5,
    parameter int CHANGE_GAP  = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         moeda5,
    input  logic         moeda10,
    input  logic         moeda25,
    input  logic         cancela,
    input  logic         pizza,
    input  logic         burguer,
    input  logic         torta,
    input  logic         soda,
    input  logic [W-1:0] gastoIn,
    output logic [W-1:0] saldoOut,
    output logic         vendendo,
    output logic         troco_pulse,
    output logic [W-1:0] troco_valor,
    output logic [W-1:0] troco_total,
    output logic         erro
);

    logic e5, e10, e25, ecan, eitem;
    logic item_any;

    assign item_any = pizza | burguer | torta | soda;

    edge_sync u_sync_m5  (.clock(clock), .reset(reset), .din(moeda5),   .pulse(e5));
    edge_sync u_sync_m10 (.clock(clock), .reset(reset), .din(moeda10),  .pulse(e10));
    edge_sync u_sync_m25 (.clock(clock), .reset(reset), .din(moeda25),  .pulse(e25));
    edge_sync u_sync_can (.clock(clock), .reset(reset), .din(cancela),  .pulse(ecan));
    edge_sync u_sync_itm (.clock(clock), .reset(reset), .din(item_any), .pulse(eitem));

    state_t       state;
    logic [W-1:0] saldo;
    logic         pending;
    logic [7:0]   vend_cnt;
    logic [7:0]   gap_cnt;

    logic [W:0]   coin_sum;
    logic [W:0]   sum_raw;
    logic [W:0]   sum_ok;
    logic         over;
    logic         coin_any;
    logic         buy_ok;
    logic         buy_bad;
    logic [W-1:0] pay;

    assign saldoOut = saldo;

    // Credit arithmetic is one bit wider than the balance so the limit check sees the true sum
    always_comb begin
        coin_sum = '0;
        if (e5)  coin_sum = coin_sum + (W+1)'(MOEDA5);
        if (e10) coin_sum = coin_sum + (W+1)'(MOEDA10);
        if (e25) coin_sum = coin_sum + (W+1)'(MOEDA25);
        coin_any = e5 | e10 | e25;
        sum_raw  = {1'b0, saldo} + coin_sum;
        over     = sum_raw > (W+1)'(SALDO_MAX);
        sum_ok   = over ? {1'b0, saldo} : sum_raw;
        buy_ok   = eitem && (gastoIn != '0) && ({1'b0, gastoIn} <= sum_ok);
        buy_bad  = eitem && !buy_ok;
        pay      = (saldo < W'(CHANGE_UNIT)) ? saldo : W'(CHANGE_UNIT);
    end

    // Main controller: balance register, vend timer, change payout, registered strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            saldo       <= '0;
            pending     <= 1'b0;
            vend_cnt    <= '0;
            gap_cnt     <= '0;
            vendendo    <= 1'b0;
            troco_pulse <= 1'b0;
            troco_valor <= '0;
            troco_total <= '0;
            erro        <= 1'b0;
        end else begin
            erro        <= 1'b0;
            troco_pulse <= 1'b0;
            troco_valor <= '0;
            unique case (state)
                S_IDLE: begin
                    if (buy_ok) begin
                        // purchase beats a simultaneous cancel; the cancel waits for vend end
                        saldo    <= W'(sum_ok - {1'b0, gastoIn});
                        erro     <= over;
                        state    <= S_VEND;
                        vendendo <= 1'b1;
                        vend_cnt <= 8'(VEND_CYCLES - 1);
                        if (ecan) pending <= 1'b1;
                    end else begin
                        saldo <= W'(sum_ok);
                        erro  <= over | buy_bad;
                        if (ecan && (sum_ok != '0)) begin
                            state       <= S_CHANGE;
                            gap_cnt     <= 8'(CHANGE_GAP - 1);
                            troco_total <= '0;
                        end
                    end
                end
                S_VEND: begin
                    erro <= coin_any;
                    if (ecan) pending <= 1'b1;
                    if (vend_cnt == '0) begin
                        vendendo <= 1'b0;
                        pending  <= 1'b0;
                        if ((pending || ecan) && (saldo != '0)) begin
                            state       <= S_CHANGE;
                            gap_cnt     <= 8'(CHANGE_GAP - 1);
                            troco_total <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        vend_cnt <= vend_cnt - 8'd1;
                    end
                end
                S_CHANGE: begin
                    erro <= coin_any;
                    if (gap_cnt == '0) begin
                        troco_pulse <= 1'b1;
                        troco_valor <= pay;
                        saldo       <= saldo - pay;
                        troco_total <= troco_total + pay;
                        gap_cnt     <= 8'(CHANGE_GAP - 1);
                        if (saldo == pay) state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
